// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with length field; short (1-2 bit) transfers are discarded.
// Optional drop_o pulse port enabled by defining DESERIALIZER_DROP_FLAG_EN.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] data_o,
    output logic [DATA_MOD_WIDTH-1:0] data_mod_o,
    output logic                      data_val_o,
    output logic                      busy_o
`ifdef DESERIALIZER_DROP_FLAG_EN
    ,
    output logic                      drop_o
`endif
);

    localparam int               CNT_W = DATA_MOD_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_BUS_WIDTH - 1);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(3);

    typedef enum logic {IDLE_S, RECV_S} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [DATA_BUS_WIDTH-1:0] shreg;
    logic [DATA_BUS_WIDTH-1:0] bit_pos;

    // Incoming bit placed at index W-1-cnt; in IDLE_S cnt is 0 so it lands at the MSB.
    assign bit_pos = {{(DATA_BUS_WIDTH-1){1'b0}}, ser_data_i} << (LAST - cnt);
    assign busy_o  = (state == RECV_S);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE_S;
            cnt        <= '0;
            shreg      <= '0;
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
`ifdef DESERIALIZER_DROP_FLAG_EN
            drop_o     <= 1'b0;
`endif
        end else begin
            data_val_o <= 1'b0;
`ifdef DESERIALIZER_DROP_FLAG_EN
            drop_o     <= 1'b0;
`endif
            case (state)
                IDLE_S: begin
                    if (ser_data_val_i) begin
                        // Fresh transfer: old buffer contents are replaced, not merged.
                        shreg <= bit_pos;
                        cnt   <= CNT_W'(1);
                        state <= RECV_S;
                    end
                end
                RECV_S: begin
                    if (ser_data_val_i) begin
                        if (cnt == LAST) begin
                            data_o     <= shreg | bit_pos;
                            data_mod_o <= '0;
                            data_val_o <= 1'b1;
                            cnt        <= '0;
                            state      <= IDLE_S;
                        end else begin
                            shreg <= shreg | bit_pos;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end else begin
                        if (cnt >= MIN_N) begin
                            data_o     <= shreg;
                            data_mod_o <= cnt[DATA_MOD_WIDTH-1:0];
                            data_val_o <= 1'b1;
                        end
`ifdef DESERIALIZER_DROP_FLAG_EN
                        else begin
                            drop_o <= 1'b1;
                        end
`endif
                        cnt   <= '0;
                        state <= IDLE_S;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE_S;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_deserializer;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [15:0] data_o;
    logic [3:0]  data_mod_o;
    logic        data_val_o;
    logic        busy_o;
`ifdef DESERIALIZER_DROP_FLAG_EN
    logic        drop_o;
`endif

    deserializer #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .data_o         (data_o),
        .data_mod_o     (data_mod_o),
        .data_val_o     (data_val_o),
        .busy_o         (busy_o)
`ifdef DESERIALIZER_DROP_FLAG_EN
        ,
        .drop_o         (drop_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  m;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_drops = 0;
    int   seen_drops = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One sampling edge per call; returns 1ns after the edge that captured these inputs.
    task automatic step(input logic v, input logic d);
        ser_data_val_i = v;
        ser_data_i     = d;
        @(posedge clk_i);
        #1;
    endtask

    // Sends the top n bits of w (MSB first); partial transfers end with one low-valid cycle.
    task automatic xfer(input logic [15:0] w, input int n, input logic [15:0] exp_d);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            step(1'b1, w[15-i]);
            if (i == 0) chk("busy_after_first_bit", 32'(busy_o), 32'd1);
        end
        if (n < 16) step(1'b0, 1'b0);
        if (n >= 3) begin
            e.d = exp_d;
            e.m = (n == 16) ? 4'd0 : 4'(n);
            e.c = cyc;
            q.push_back(e);
        end else begin
            exp_drops++;
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (data_val_o) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(data_o), 32'hDEAD);
            end else begin
                e = q.pop_front();
                chk("data_o", 32'(data_o), 32'(e.d));
                chk("data_mod_o", 32'(data_mod_o), 32'(e.m));
                chk("strobe_cycle", 32'(cyc), 32'(e.c));
                chk("busy_at_strobe", 32'(busy_o), 32'd0);
            end
        end
`ifdef DESERIALIZER_DROP_FLAG_EN
        if (drop_o) seen_drops++;
`endif
    end

    initial begin
        repeat (3) step(1'b0, 1'b0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_mod", 32'(data_mod_o), 32'd0);
        chk("rst_val", 32'(data_val_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        srst_i = 1'b0;
        step(1'b0, 1'b0);

        xfer(16'hA5C3, 16, 16'hA5C3);
        step(1'b0, 1'b0);
        xfer(16'hB000, 5, 16'hB000);
        xfer(16'hC000, 2, 16'h0000);
        step(1'b0, 1'b0);
        chk("hold_data_after_drop", 32'(data_o), 32'hB000);
        chk("hold_mod_after_drop", 32'(data_mod_o), 32'd5);
        chk("busy_idle_after_drop", 32'(busy_o), 32'd0);

        xfer(16'h1234, 16, 16'h1234);
        xfer(16'hFFFF, 16, 16'hFFFF);
        step(1'b0, 1'b0);
        xfer(16'hE000, 3, 16'hE000);
        xfer(16'h1000, 4, 16'h1000);
        xfer(16'h8000, 1, 16'h0000);
        xfer(16'h6000, 3, 16'h6000);

        // Reset lands after bit 7 of a 10-bit transfer.
        for (int i = 0; i < 7; i++) step(1'b1, 1'(i % 2));
        srst_i = 1'b1;
        step(1'b1, 1'b1);
        chk("midrst_data_o", 32'(data_o), 32'd0);
        chk("midrst_mod", 32'(data_mod_o), 32'd0);
        chk("midrst_val", 32'(data_val_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        srst_i = 1'b0;
        xfer(16'h5A0F, 16, 16'h5A0F);

        repeat (5) step(1'b0, 1'b0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
`ifdef DESERIALIZER_DROP_FLAG_EN
        chk("drop_pulses", 32'(seen_drops), 32'(exp_drops));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
